// File: rtl/dual_port_ram_pkg.sv
// Shared request decode for the dual-port RAM slice: classifies each port's
// enable/write-enable pair into an idle, read or write request.
package dual_port_ram_pkg;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_e;

  function automatic req_e decode_req(input logic en, input logic we);
    if (!en) return REQ_IDLE;
    return we ? REQ_WRITE : REQ_READ;
  endfunction

endpackage

// File: rtl/latency_pipe.sv
// Fixed-depth shift register carrying a payload alongside a valid bit; only the
// valid bits are cleared by reset, so flushed payloads can never be acted on.
module latency_pipe #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_p;
  logic [DEPTH:0]   vld_shift;
  logic [WIDTH-1:0] data_p [DEPTH];

  // Entry valid sits at bit 0, so the same slice works for DEPTH == 1
  assign vld_shift = {vld_p, in_vld};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p <= '0;
    else        vld_p <= vld_shift[DEPTH-1:0];
  end

  always_ff @(posedge clk) begin
    data_p[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) data_p[i] <= data_p[i-1];
  end

  assign out_vld  = vld_p[DEPTH-1];
  assign out_data = data_p[DEPTH-1];

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with pipelined write commit and read return; reads see the
// array as it was before the accepting edge, and port A wins same-address commits.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_dina,
  input  logic [ADDR_WIDTH-1:0] i_addra,
  input  logic                  i_ena,
  input  logic                  i_wea,
  input  logic [DATA_WIDTH-1:0] i_dinb,
  input  logic [ADDR_WIDTH-1:0] i_addrb,
  input  logic                  i_enb,
  input  logic                  i_web,
  output logic [DATA_WIDTH-1:0] o_douta,
  output logic [DATA_WIDTH-1:0] o_doutb
);

  localparam int WR_W = ADDR_WIDTH + DATA_WIDTH;

  req_e req_a, req_b;

  always_comb begin
    req_a = decode_req(i_ena, i_wea);
    req_b = decode_req(i_enb, i_web);
  end

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic                  wr_vld_a, wr_vld_b;
  logic [WR_W-1:0]       wr_pkt_a, wr_pkt_b;
  logic                  rd_vld_a, rd_vld_b;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;

  // Write request stages: {addr, data} travels until its commit edge
  latency_pipe #(.DEPTH(WRITE_LATENCY), .WIDTH(WR_W)) u_wr_pipe_a (
    .clk(i_clk), .rst_n(i_rst_n),
    .in_vld(req_a == REQ_WRITE), .in_data({i_addra, i_dina}),
    .out_vld(wr_vld_a), .out_data(wr_pkt_a)
  );

  latency_pipe #(.DEPTH(WRITE_LATENCY), .WIDTH(WR_W)) u_wr_pipe_b (
    .clk(i_clk), .rst_n(i_rst_n),
    .in_vld(req_b == REQ_WRITE), .in_data({i_addrb, i_dinb}),
    .out_vld(wr_vld_b), .out_data(wr_pkt_b)
  );

  // Commit stage: port A is assigned last so it wins an address collision
  always_ff @(posedge i_clk) begin
    if (wr_vld_b) mem[wr_pkt_b[WR_W-1:DATA_WIDTH]] <= wr_pkt_b[DATA_WIDTH-1:0];
    if (wr_vld_a) mem[wr_pkt_a[WR_W-1:DATA_WIDTH]] <= wr_pkt_a[DATA_WIDTH-1:0];
  end

  // Read capture stage: array sampled before this edge's commit lands
  latency_pipe #(.DEPTH(READ_LATENCY), .WIDTH(DATA_WIDTH)) u_rd_pipe_a (
    .clk(i_clk), .rst_n(i_rst_n),
    .in_vld(req_a == REQ_READ), .in_data(mem[i_addra]),
    .out_vld(rd_vld_a), .out_data(rd_data_a)
  );

  latency_pipe #(.DEPTH(READ_LATENCY), .WIDTH(DATA_WIDTH)) u_rd_pipe_b (
    .clk(i_clk), .rst_n(i_rst_n),
    .in_vld(req_b == REQ_READ), .in_data(mem[i_addrb]),
    .out_vld(rd_vld_b), .out_data(rd_data_b)
  );

  // Output stage: holds the last returned word between valid reads
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_douta <= '0;
      o_doutb <= '0;
    end else begin
      if (rd_vld_a) o_douta <= rd_data_a;
      if (rd_vld_b) o_doutb <= rd_data_b;
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: reads push hand-computed expectations into
// per-port queues tagged with their due edge; a monitor pops and compares.
module tb_dual_port_ram;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  dina = '0, dinb = '0;
  logic [11:0] addra = '0, addrb = '0;
  logic        ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
  logic [7:0]  douta, doutb;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] last_a = '0, last_b = '0;

  dual_port_ram #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .READ_LATENCY(LAT), .WRITE_LATENCY(LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dina(dina), .i_addra(addra), .i_ena(ena), .i_wea(wea),
    .i_dinb(dinb), .i_addrb(addrb), .i_enb(enb), .i_web(web),
    .o_douta(douta), .o_doutb(doutb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: runs 1 time unit after every rising edge
  always begin
    @(posedge clk);
    #1;
    if (armed) begin
      if (!rst_n) begin
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        check("reset_douta", douta, 8'h00);
        check("reset_doutb", doutb, 8'h00);
      end else begin
        if (qa.size() > 0 && qa[0].due == cyc) begin
          check("read_a", douta, qa[0].data);
          last_a = qa[0].data;
          void'(qa.pop_front());
        end else begin
          check("hold_a", douta, last_a);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
          check("read_b", doutb, qb[0].data);
          last_b = qb[0].data;
          void'(qb.pop_front());
        end else begin
          check("hold_b", doutb, last_b);
        end
      end
    end
  end

  // One cycle of stimulus; a read pushes its expected value due LAT edges later
  task automatic drive(input logic ea, input logic wa, input logic [11:0] aa,
                       input logic [7:0] da,
                       input logic eb, input logic wb, input logic [11:0] ab,
                       input logic [7:0] db);
    @(negedge clk);
    ena = ea; wea = wa; addra = aa; dina = wa ? da : 8'h00;
    enb = eb; web = wb; addrb = ab; dinb = wb ? db : 8'h00;
    if (ea && !wa) qa.push_back('{cyc + 1 + LAT, da});
    if (eb && !wb) qb.push_back('{cyc + 1 + LAT, db});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
  endtask

  // For reads, the data argument is the expected read value
  task automatic wr_a(input logic [11:0] a, input logic [7:0] d);
    drive(1, 1, a, d, 0, 0, 12'h000, 8'h00);
  endtask
  task automatic rd_a(input logic [11:0] a, input logic [7:0] x);
    drive(1, 0, a, x, 0, 0, 12'h000, 8'h00);
  endtask
  task automatic wr_b(input logic [11:0] a, input logic [7:0] d);
    drive(0, 0, 12'h000, 8'h00, 1, 1, a, d);
  endtask

  task automatic reset_for(input int n);
    @(negedge clk);
    ena = 0; enb = 0; wea = 0; web = 0;
    rst_n = 1'b0;
    armed = 1'b1;
    for (int i = 1; i < n; i++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset, then quiet cycles: outputs must stay 0
    reset_for(3);
    idle(3);

    // Port A write then read after commit
    wr_a(12'h123, 8'h5A);
    idle(3);
    rd_a(12'h123, 8'h5A);
    idle(4);

    // Cross-port: read at commit edge sees old data, next edge sees new
    wr_a(12'h7FF, 8'h3C);
    idle(3);
    wr_b(12'h7FF, 8'hC3);
    idle(2);
    rd_a(12'h7FF, 8'h3C);
    rd_a(12'h7FF, 8'hC3);
    idle(4);

    // Same-address collision: A wins; different addresses in the same cycle both land
    drive(1, 1, 12'h010, 8'h11, 1, 1, 12'h010, 8'h22);
    drive(1, 1, 12'h011, 8'h44, 1, 1, 12'h012, 8'h55);
    idle(3);
    drive(1, 0, 12'h010, 8'h11, 1, 0, 12'h010, 8'h11);
    drive(1, 0, 12'h012, 8'h55, 1, 0, 12'h011, 8'h44);
    idle(4);

    // Back-to-back reads on both ports
    drive(1, 1, 12'h000, 8'hA0, 1, 1, 12'h002, 8'hA2);
    drive(1, 1, 12'h001, 8'hA1, 1, 1, 12'h003, 8'hA3);
    idle(3);
    for (int i = 0; i < 4; i++)
      drive(1, 0, 12'(i), 8'hA0 + 8'(i), 1, 0, 12'(i), 8'hA0 + 8'(i));
    idle(4);

    // Mid-operation reset: in-flight write discarded, in-flight read silent
    wr_a(12'h020, 8'h33);
    idle(3);
    drive(1, 1, 12'h020, 8'hEE, 1, 0, 12'h123, 8'h5A);
    reset_for(2);
    idle(4);
    drive(1, 0, 12'h020, 8'h33, 1, 0, 12'h020, 8'h33);
    idle(1);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) idle(1);
    if (qa.size() > 0 || qb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d reads outstanding, required 0/0", qa.size(), qb.size());
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
